// File: rtl/csr_commit_ctrl_if.sv
// MEM->WB retire bundle, CSR file request/response and GPR write port of csr_commit_ctrl.
// Trace fields exist only when CSR_COMMIT_TRACE_EN is defined.
interface csr_commit_ctrl_if #(
  parameter int CSR_NUM_W = 14
);
  logic                 ms_to_ws_valid;
  logic                 ws_allowin;
  logic [31:0]          ms_pc;
  logic [1:0]           ms_csr_op;
  logic [CSR_NUM_W-1:0] ms_csr_num;
  logic [31:0]          ms_rj_value;
  logic [31:0]          ms_rd_value;
  logic                 ms_ertn;
  logic                 ms_ex;
  logic [5:0]           ms_ecode;
  logic [8:0]           ms_esubcode;
  logic [31:0]          ms_vaddr;
  logic                 ms_gr_we;
  logic [4:0]           ms_dest;
  logic [31:0]          ms_result;
  logic                 has_int;
  logic                 csr_re;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [31:0]          csr_rvalue;
  logic                 csr_we;
  logic [31:0]          csr_wmask;
  logic [31:0]          csr_wvalue;
  logic                 wb_ex;
  logic                 ertn_flush;
  logic [31:0]          wb_pc;
  logic [31:0]          wb_vaddr;
  logic [5:0]           wb_ecode;
  logic [8:0]           wb_esubcode;
  logic [31:0]          csr_eentry_data;
  logic [31:0]          csr_era_pc;
  logic                 flush_valid;
  logic [31:0]          flush_target;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [31:0]          rf_wdata;
`ifdef CSR_COMMIT_TRACE_EN
  logic [31:0]          debug_wb_pc;
  logic [3:0]           debug_wb_rf_we;
  logic [4:0]           debug_wb_rf_wnum;
  logic [31:0]          debug_wb_rf_wdata;
`endif

`ifdef CSR_COMMIT_TRACE_EN
  modport master (
    input  ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest, ms_result,
           has_int, csr_rvalue, csr_eentry_data, csr_era_pc,
    output ws_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, ertn_flush,
           wb_pc, wb_vaddr, wb_ecode, wb_esubcode, flush_valid, flush_target,
           rf_we, rf_waddr, rf_wdata,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
  modport slave (
    output ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest, ms_result,
           has_int, csr_rvalue, csr_eentry_data, csr_era_pc,
    input  ws_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, ertn_flush,
           wb_pc, wb_vaddr, wb_ecode, wb_esubcode, flush_valid, flush_target,
           rf_we, rf_waddr, rf_wdata,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
`else
  modport master (
    input  ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest, ms_result,
           has_int, csr_rvalue, csr_eentry_data, csr_era_pc,
    output ws_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, ertn_flush,
           wb_pc, wb_vaddr, wb_ecode, wb_esubcode, flush_valid, flush_target,
           rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    output ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_gr_we, ms_dest, ms_result,
           has_int, csr_rvalue, csr_eentry_data, csr_era_pc,
    input  ws_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, ertn_flush,
           wb_pc, wb_vaddr, wb_ecode, wb_esubcode, flush_valid, flush_target,
           rf_we, rf_waddr, rf_wdata
  );
`endif
endinterface

// File: rtl/csr_commit_ctrl.sv
// Write-back commit controller: retires one instruction per cycle, drives CSR/GPR writes,
// raises exception/ertn flushes and then drains. Define CSR_COMMIT_TRACE_EN for trace outputs.
module csr_commit_ctrl #(
  parameter int FLUSH_DRAIN = 2,
  parameter int CSR_NUM_W   = 14
) (
  input logic              clk,
  input logic              resetn,
  csr_commit_ctrl_if.master bus
);
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_DRAIN);

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 allowin_q;

  logic                 ws_valid_q, ws_valid_d;
  logic [31:0]          ws_pc_q;
  logic [1:0]           ws_csr_op_q;
  logic [CSR_NUM_W-1:0] ws_csr_num_q;
  logic [31:0]          ws_rj_value_q;
  logic [31:0]          ws_rd_value_q;
  logic                 ws_ertn_q;
  logic                 ws_ex_q;
  logic [5:0]           ws_ecode_q;
  logic [8:0]           ws_esubcode_q;
  logic [31:0]          ws_vaddr_q;
  logic                 ws_gr_we_q;
  logic [4:0]           ws_dest_q;
  logic [31:0]          ws_result_q;

  logic capture;
  logic exc_commit;
  logic ertn_commit;
  logic flush;
  logic csr_write;

  assign exc_commit  = ws_valid_q && (ws_ex_q || bus.has_int);
  assign ertn_commit = ws_valid_q && ws_ertn_q && !exc_commit;
  assign flush       = exc_commit || ertn_commit;
  assign csr_write   = ws_valid_q && !flush && ws_csr_op_q[1];

  // A bundle offered in the same cycle as a flush belongs to the squashed path.
  assign capture    = bus.ms_to_ws_valid && allowin_q && !flush;
  assign ws_valid_d = capture;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_q    <= 1'b0;
      ws_pc_q       <= '0;
      ws_csr_op_q   <= '0;
      ws_csr_num_q  <= '0;
      ws_rj_value_q <= '0;
      ws_rd_value_q <= '0;
      ws_ertn_q     <= 1'b0;
      ws_ex_q       <= 1'b0;
      ws_ecode_q    <= '0;
      ws_esubcode_q <= '0;
      ws_vaddr_q    <= '0;
      ws_gr_we_q    <= 1'b0;
      ws_dest_q     <= '0;
      ws_result_q   <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      if (capture) begin
        ws_pc_q       <= bus.ms_pc;
        ws_csr_op_q   <= bus.ms_csr_op;
        ws_csr_num_q  <= bus.ms_csr_num;
        ws_rj_value_q <= bus.ms_rj_value;
        ws_rd_value_q <= bus.ms_rd_value;
        ws_ertn_q     <= bus.ms_ertn;
        ws_ex_q       <= bus.ms_ex;
        ws_ecode_q    <= bus.ms_ecode;
        ws_esubcode_q <= bus.ms_esubcode;
        ws_vaddr_q    <= bus.ms_vaddr;
        ws_gr_we_q    <= bus.ms_gr_we;
        ws_dest_q     <= bus.ms_dest;
        ws_result_q   <= bus.ms_result;
      end
    end
  end

  // FLUSH holds one cycle, DRAIN counts FLUSH_DRAIN cycles down to 1 before reopening.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      allowin_q <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_q   <= ST_FLUSH;
            cnt_q     <= DRAIN_LOAD;
            allowin_q <= 1'b0;
          end
        end
        ST_FLUSH: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (cnt_q <= 4'd1) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            allowin_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          cnt_q     <= '0;
          allowin_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ws_allowin = allowin_q;

  always_comb begin
    bus.csr_re       = ws_valid_q && !flush && (ws_csr_op_q != 2'd0);
    bus.csr_num      = ws_csr_num_q;
    bus.csr_we       = csr_write;
    bus.csr_wmask    = '0;
    bus.csr_wvalue   = '0;
    if (csr_write) begin
      bus.csr_wmask  = ws_csr_op_q[0] ? ws_rj_value_q : 32'hFFFF_FFFF;
      bus.csr_wvalue = ws_rd_value_q;
    end
    bus.wb_ex        = exc_commit;
    bus.ertn_flush   = ertn_commit;
    bus.wb_pc        = '0;
    bus.wb_vaddr     = '0;
    bus.wb_ecode     = '0;
    bus.wb_esubcode  = '0;
    // Interrupts report ecode/esubcode 0; upstream exceptions carry their own codes.
    if (exc_commit) begin
      bus.wb_pc      = ws_pc_q;
      bus.wb_vaddr   = ws_vaddr_q;
      if (ws_ex_q) begin
        bus.wb_ecode    = ws_ecode_q;
        bus.wb_esubcode = ws_esubcode_q;
      end
    end
    bus.flush_valid  = flush;
    bus.flush_target = exc_commit  ? bus.csr_eentry_data :
                       ertn_commit ? bus.csr_era_pc : 32'h0;
    bus.rf_we        = ws_valid_q && ws_gr_we_q && !flush && (ws_dest_q != 5'd0);
    bus.rf_waddr     = ws_dest_q;
    bus.rf_wdata     = (ws_csr_op_q != 2'd0) ? bus.csr_rvalue : ws_result_q;
  end

`ifdef CSR_COMMIT_TRACE_EN
  assign bus.debug_wb_pc       = ws_pc_q;
  assign bus.debug_wb_rf_we    = {4{bus.rf_we}};
  assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
  assign bus.debug_wb_rf_wdata = bus.rf_wdata;
`endif
endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed vector bench for csr_commit_ctrl (FLUSH_DRAIN=2) plus drain/reset corner sequences.
module tb_csr_commit_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_0104;

  csr_commit_ctrl_if #(.CSR_NUM_W(14)) bus ();

  csr_commit_ctrl #(.FLUSH_DRAIN(2), .CSR_NUM_W(14)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;  logic [13:0] num; logic [31:0] rj;  logic [31:0] rd;
    logic [31:0] rv;  logic        gr_we; logic [4:0] dest; logic [31:0] res;
    logic        ex;  logic [5:0]  ecode; logic [8:0] esub; logic ertn; logic intr;
    logic [31:0] pc;
    logic        e_csr_we; logic [31:0] e_wmask; logic e_rf_we; logic [31:0] e_wdata;
    logic        e_wb_ex;  logic [5:0]  e_ecode; logic [8:0] e_esub; logic e_ertn;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mkv(
    input logic [1:0] op, input logic [13:0] num, input logic [31:0] rj, input logic [31:0] rd,
    input logic [31:0] rv, input logic gr_we, input logic [4:0] dest, input logic [31:0] res,
    input logic ex, input logic [5:0] ecode, input logic [8:0] esub, input logic ertn,
    input logic intr, input logic [31:0] pc,
    input logic e_csr_we, input logic [31:0] e_wmask, input logic e_rf_we, input logic [31:0] e_wdata,
    input logic e_wb_ex, input logic [5:0] e_ecode, input logic [8:0] e_esub, input logic e_ertn,
    input logic [31:0] e_target);
    vec_t v;
    v.op = op; v.num = num; v.rj = rj; v.rd = rd; v.rv = rv; v.gr_we = gr_we; v.dest = dest;
    v.res = res; v.ex = ex; v.ecode = ecode; v.esub = esub; v.ertn = ertn; v.intr = intr; v.pc = pc;
    v.e_csr_we = e_csr_we; v.e_wmask = e_wmask; v.e_rf_we = e_rf_we; v.e_wdata = e_wdata;
    v.e_wb_ex = e_wb_ex; v.e_ecode = e_ecode; v.e_esub = e_esub; v.e_ertn = e_ertn;
    v.e_target = e_target;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.ms_to_ws_valid = 1'b0; bus.ms_pc = '0; bus.ms_csr_op = '0; bus.ms_csr_num = '0;
    bus.ms_rj_value = '0; bus.ms_rd_value = '0; bus.ms_ertn = 1'b0; bus.ms_ex = 1'b0;
    bus.ms_ecode = '0; bus.ms_esubcode = '0; bus.ms_vaddr = '0; bus.ms_gr_we = 1'b0;
    bus.ms_dest = '0; bus.ms_result = '0; bus.has_int = 1'b0; bus.csr_rvalue = '0;
    bus.csr_eentry_data = EENTRY; bus.csr_era_pc = ERA;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.ms_pc = v.pc; bus.ms_csr_op = v.op; bus.ms_csr_num = v.num; bus.ms_rj_value = v.rj;
    bus.ms_rd_value = v.rd; bus.ms_ertn = v.ertn; bus.ms_ex = v.ex; bus.ms_ecode = v.ecode;
    bus.ms_esubcode = v.esub; bus.ms_vaddr = v.pc ^ 32'h0000_0F00; bus.ms_gr_we = v.gr_we;
    bus.ms_dest = v.dest; bus.ms_result = v.res; bus.has_int = v.intr; bus.csr_rvalue = v.rv;
    bus.ms_to_ws_valid = 1'b1;
  endtask

  // Waits (bounded) at negedges until the stage accepts again.
  task automatic wait_allowin(input string name);
    int n = 0;
    while (bus.ws_allowin !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.ws_allowin !== 1'b1) check(name, {31'b0, bus.ws_allowin}, 32'd1);
  endtask

  vec_t sc;
  int   lows;

  initial begin
    drive_idle();
    vecs[0] = mkv(2'd3, 14'h30, 32'h0000FFFF, 32'h12345678, 32'hAAAA5555, 1, 5'd4, 32'h0, 0, 6'h0, 9'h0, 0, 0, 32'h1C000010,
                  1, 32'h0000FFFF, 1, 32'hAAAA5555, 0, 6'h0, 9'h0, 0, 32'h0);
    vecs[1] = mkv(2'd2, 14'h01, 32'h0, 32'hCAFEBABE, 32'h11112222, 1, 5'd5, 32'h0, 0, 6'h0, 9'h0, 0, 0, 32'h1C000014,
                  1, 32'hFFFFFFFF, 1, 32'h11112222, 0, 6'h0, 9'h0, 0, 32'h0);
    vecs[2] = mkv(2'd1, 14'h06, 32'h0, 32'h0, 32'h0BADF00D, 1, 5'd6, 32'h0, 0, 6'h0, 9'h0, 0, 0, 32'h1C000018,
                  0, 32'h0, 1, 32'h0BADF00D, 0, 6'h0, 9'h0, 0, 32'h0);
    vecs[3] = mkv(2'd0, 14'h00, 32'h0, 32'h0, 32'h77777777, 1, 5'd9, 32'hDEADBEEF, 0, 6'h0, 9'h0, 0, 0, 32'h1C00001C,
                  0, 32'h0, 1, 32'hDEADBEEF, 0, 6'h0, 9'h0, 0, 32'h0);
    vecs[4] = mkv(2'd0, 14'h00, 32'h0, 32'h0, 32'h0, 1, 5'd0, 32'h13572468, 0, 6'h0, 9'h0, 0, 0, 32'h1C000020,
                  0, 32'h0, 0, 32'h0, 0, 6'h0, 9'h0, 0, 32'h0);
    vecs[5] = mkv(2'd0, 14'h00, 32'h0, 32'h0, 32'h0, 1, 5'd3, 32'h5, 1, 6'h0B, 9'h0, 0, 0, 32'h1C000100,
                  0, 32'h0, 0, 32'h0, 1, 6'h0B, 9'h0, 0, EENTRY);
    vecs[6] = mkv(2'd0, 14'h00, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 6'h0, 9'h0, 1, 0, 32'h1C000200,
                  0, 32'h0, 0, 32'h0, 0, 6'h0, 9'h0, 1, ERA);
    vecs[7] = mkv(2'd2, 14'h05, 32'h0, 32'h00000042, 32'h99990000, 1, 5'd8, 32'h0, 0, 6'h0, 9'h0, 0, 1, 32'h1C000300,
                  0, 32'h0, 0, 32'h0, 1, 6'h0, 9'h0, 0, EENTRY);
    vecs[8] = mkv(2'd0, 14'h00, 32'h0, 32'h0, 32'h0, 1, 5'd2, 32'h0, 1, 6'h08, 9'h1, 1, 1, 32'h1C000400,
                  0, 32'h0, 0, 32'h0, 1, 6'h08, 9'h1, 0, EENTRY);

    // Reset held two cycles
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_allowin", {31'b0, bus.ws_allowin}, 32'd1);
    check("rst_strobes", {28'b0, bus.wb_ex, bus.csr_we, bus.rf_we, bus.flush_valid}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    $display("reset released: allowin=%b", bus.ws_allowin);

    for (int i = 0; i < 9; i++) begin
      wait_allowin("allowin_timeout");
      drive_vec(vecs[i]);
      @(negedge clk);
      bus.ms_to_ws_valid = 1'b0;
      $display("vec %0d: op=%0d ex=%b ertn=%b int=%b -> csr_we=%b rf_we=%b wb_ex=%b ertn_flush=%b flush=%b tgt=%h",
               i, vecs[i].op, vecs[i].ex, vecs[i].ertn, vecs[i].intr, bus.csr_we, bus.rf_we,
               bus.wb_ex, bus.ertn_flush, bus.flush_valid, bus.flush_target);
      check($sformatf("v%0d_csr_we", i), {31'b0, bus.csr_we}, {31'b0, vecs[i].e_csr_we});
      check($sformatf("v%0d_wmask", i), bus.csr_wmask, vecs[i].e_wmask);
      check($sformatf("v%0d_rf_we", i), {31'b0, bus.rf_we}, {31'b0, vecs[i].e_rf_we});
      check($sformatf("v%0d_wb_ex", i), {31'b0, bus.wb_ex}, {31'b0, vecs[i].e_wb_ex});
      check($sformatf("v%0d_ertn", i), {31'b0, bus.ertn_flush}, {31'b0, vecs[i].e_ertn});
      check($sformatf("v%0d_flush", i), {31'b0, bus.flush_valid}, {31'b0, vecs[i].e_wb_ex | vecs[i].e_ertn});
      check($sformatf("v%0d_target", i), bus.flush_target, vecs[i].e_target);
      if (vecs[i].e_rf_we) begin
        check($sformatf("v%0d_wdata", i), bus.rf_wdata, vecs[i].e_wdata);
        check($sformatf("v%0d_waddr", i), {27'b0, bus.rf_waddr}, {27'b0, vecs[i].dest});
      end
      if (vecs[i].e_csr_we) begin
        check($sformatf("v%0d_wvalue", i), bus.csr_wvalue, vecs[i].rd);
        check($sformatf("v%0d_csr_num", i), {18'b0, bus.csr_num}, {18'b0, vecs[i].num});
      end
      if (!(vecs[i].e_wb_ex | vecs[i].e_ertn))
        check($sformatf("v%0d_csr_re", i), {31'b0, bus.csr_re}, {31'b0, vecs[i].op != 2'd0});
      if (vecs[i].e_wb_ex) begin
        check($sformatf("v%0d_ecode", i), {26'b0, bus.wb_ecode}, {26'b0, vecs[i].e_ecode});
        check($sformatf("v%0d_esub", i), {23'b0, bus.wb_esubcode}, {23'b0, vecs[i].e_esub});
        check($sformatf("v%0d_wb_pc", i), bus.wb_pc, vecs[i].pc);
      end
      @(negedge clk);
      check($sformatf("v%0d_once", i), {28'b0, bus.wb_ex, bus.ertn_flush, bus.flush_valid, bus.rf_we}, 32'd0);
      bus.has_int = 1'b0;
    end

    // Syscall: allowin must stay low for FLUSH + FLUSH_DRAIN cycles
    wait_allowin("allowin_timeout");
    drive_vec(vecs[5]);
    @(negedge clk);
    bus.ms_to_ws_valid = 1'b0;
    check("sys_wb_ex", {31'b0, bus.wb_ex}, 32'd1);
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ws_allowin === 1'b1) break;
      lows++;
    end
    $display("syscall drain: allowin low for %0d cycles", lows);
    check("sys_drain_len", lows, 32'd3);

    // Back-to-back valid from the flush cycle on: nothing captured until allowin returns
    wait_allowin("allowin_timeout");
    drive_vec(vecs[5]);
    @(negedge clk);
    check("b2b_flush", {31'b0, bus.flush_valid}, 32'd1);
    sc = vecs[3];
    sc.dest = 5'd7; sc.res = 32'h55AA_33CC; sc.pc = 32'h1C000500;
    drive_vec(sc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b2b_no_capture", {31'b0, bus.rf_we}, 32'd0);
      if (bus.ws_allowin === 1'b1) break;
    end
    check("b2b_reopen", {31'b0, bus.ws_allowin}, 32'd1);
    @(negedge clk);
    bus.ms_to_ws_valid = 1'b0;
    $display("b2b first capture: rf_we=%b waddr=%0d wdata=%h", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    check("b2b_rf_we", {31'b0, bus.rf_we}, 32'd1);
    check("b2b_waddr", {27'b0, bus.rf_waddr}, 32'd7);
    check("b2b_wdata", bus.rf_wdata, 32'h55AA_33CC);
    @(negedge clk);
    check("b2b_once", {31'b0, bus.rf_we}, 32'd0);

    // Reset during DRAIN returns to RUN immediately
    wait_allowin("allowin_timeout");
    drive_vec(vecs[6]);
    @(negedge clk);
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstdrain_low", {31'b0, bus.ws_allowin}, 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    $display("reset in drain: allowin=%b", bus.ws_allowin);
    check("rstdrain_run", {31'b0, bus.ws_allowin}, 32'd1);
    check("rstdrain_strobes", {28'b0, bus.wb_ex, bus.ertn_flush, bus.flush_valid, bus.rf_we}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rstdrain_stay", {31'b0, bus.ws_allowin}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
